// File: rtl/seven_seg_scan_driver.sv
// ============================================================================
// Module  : seven_seg_scan_driver
// Brief   : 4-digit multiplexed 7-segment driver with per-frame input shadowing,
//           leading-zero blanking, decimal points and global enable.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_seg_scan_driver #(
    parameter int REFRESH_DIV = 100_000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic        blank_leading_zeros,
    input  logic        enable,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_start
);

    localparam int               CNT_W       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] c_PRESC_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0]       c_SEG_OFF   = {7{ACTIVE_LOW}};
    localparam logic [3:0]       c_AN_OFF    = {4{ACTIVE_LOW}};
    localparam logic             c_DP_OFF    = ACTIVE_LOW;

    logic [CNT_W-1:0] prescaler_q, prescaler_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      sh_digits_q, sh_digits_d;
    logic [3:0]       sh_dp_q, sh_dp_d;
    logic             sh_blz_q, sh_blz_d;
    logic             frame_start_q, frame_start_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic [3:0]       an_q, an_d;

    logic             w_tick;
    logic             w_load;
    logic [3:0]       w_blank;
    logic [3:0]       w_cur_digit;
    logic             w_lit;

    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        case (v)
            4'h0: hex_glyph = 7'h3F;
            4'h1: hex_glyph = 7'h06;
            4'h2: hex_glyph = 7'h5B;
            4'h3: hex_glyph = 7'h4F;
            4'h4: hex_glyph = 7'h66;
            4'h5: hex_glyph = 7'h6D;
            4'h6: hex_glyph = 7'h7D;
            4'h7: hex_glyph = 7'h07;
            4'h8: hex_glyph = 7'h7F;
            4'h9: hex_glyph = 7'h6F;
            4'hA: hex_glyph = 7'h77;
            4'hB: hex_glyph = 7'h7C;
            4'hC: hex_glyph = 7'h39;
            4'hD: hex_glyph = 7'h5E;
            4'hE: hex_glyph = 7'h79;
            default: hex_glyph = 7'h71;
        endcase
    endfunction

    assign w_tick = (prescaler_q == c_PRESC_MAX);
    // The last slot's tick both wraps the scan and refreshes the shadows.
    assign w_load = w_tick && (idx_q == 2'd3);

    // Blanking ripples from the leftmost digit; a requested dp keeps a zero lit.
    assign w_blank[3] = sh_blz_q   && (sh_digits_q[15:12] == 4'h0) && !sh_dp_q[3];
    assign w_blank[2] = w_blank[3] && (sh_digits_q[11:8]  == 4'h0) && !sh_dp_q[2];
    assign w_blank[1] = w_blank[2] && (sh_digits_q[7:4]   == 4'h0) && !sh_dp_q[1];
    assign w_blank[0] = 1'b0;

    always_comb begin
        w_cur_digit = sh_digits_q[3:0];
        case (idx_q)
            2'd1:    w_cur_digit = sh_digits_q[7:4];
            2'd2:    w_cur_digit = sh_digits_q[11:8];
            2'd3:    w_cur_digit = sh_digits_q[15:12];
            default: w_cur_digit = sh_digits_q[3:0];
        endcase
    end

    assign w_lit = enable && !w_blank[idx_q];

    always_comb begin
        prescaler_d   = w_tick ? '0 : prescaler_q + CNT_W'(1);
        idx_d         = w_tick ? idx_q + 2'd1 : idx_q;
        sh_digits_d   = sh_digits_q;
        sh_dp_d       = sh_dp_q;
        sh_blz_d      = sh_blz_q;
        frame_start_d = w_load;
        if (w_load) begin
            sh_digits_d = digits_in;
            sh_dp_d     = dp_in;
            sh_blz_d    = blank_leading_zeros;
        end
        seg_d = c_SEG_OFF;
        dp_d  = c_DP_OFF;
        an_d  = c_AN_OFF;
        if (w_lit) begin
            seg_d = c_SEG_OFF ^ hex_glyph(w_cur_digit);
            dp_d  = c_DP_OFF ^ sh_dp_q[idx_q];
            an_d  = c_AN_OFF ^ (4'b0001 << idx_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler_q   <= c_PRESC_MAX;
            idx_q         <= 2'd3;
            sh_digits_q   <= '0;
            sh_dp_q       <= '0;
            sh_blz_q      <= 1'b0;
            frame_start_q <= 1'b0;
            seg_q         <= c_SEG_OFF;
            dp_q          <= c_DP_OFF;
            an_q          <= c_AN_OFF;
        end else begin
            prescaler_q   <= prescaler_d;
            idx_q         <= idx_d;
            sh_digits_q   <= sh_digits_d;
            sh_dp_q       <= sh_dp_d;
            sh_blz_q      <= sh_blz_d;
            frame_start_q <= frame_start_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            an_q          <= an_d;
        end
    end

    assign seg         = seg_q;
    assign dp          = dp_q;
    assign an          = an_q;
    assign frame_start = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_scan_driver.sv
// ============================================================================
// Module  : tb_seven_seg_scan_driver
// Brief   : Directed self-checking bench for seven_seg_scan_driver
//           (REFRESH_DIV=4, ACTIVE_LOW=1; {an,seg,dp} checked per cycle).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seven_seg_scan_driver;

    logic        clk;
    logic        reset;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        blank_leading_zeros;
    logic        enable;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_start;

    int vectors;
    int errors;

    seven_seg_scan_driver #(
        .REFRESH_DIV (4),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .digits_in           (digits_in),
        .dp_in               (dp_in),
        .blank_leading_zeros (blank_leading_zeros),
        .enable              (enable),
        .seg                 (seg),
        .dp                  (dp),
        .an                  (an),
        .frame_start         (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns on the falling edge right after the shadow-load edge.
    task automatic wait_frame;
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_start !== 1'b1 && n < 40);
        if (frame_start !== 1'b1) begin
            vectors++;
            errors++;
            $display("FAIL wait_frame: frame_start=%b required 1 within 40 cycles", frame_start);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        digits_in = 16'h1234;
        dp_in = 4'b0000;
        blank_leading_zeros = 1'b0;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({an, seg, dp, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset: an=%b seg=%h dp=%b fs=%b required an=1111 seg=7f dp=1 fs=0",
                     an, seg, dp, frame_start);
        end
    endtask

    task automatic test_scan;
        logic [11:0] exp [4];
        int s;
        exp[0] = {4'b1110, 7'h19, 1'b1};
        exp[1] = {4'b1101, 7'h30, 1'b1};
        exp[2] = {4'b1011, 7'h24, 1'b1};
        exp[3] = {4'b0111, 7'h79, 1'b1};
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL scan_first_frame_start: frame_start=%b required 1", frame_start);
        end
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            s = ((k - 1) / 4) % 4;
            vectors++;
            if ({an, seg, dp} !== exp[s]) begin
                errors++;
                $display("FAIL scan k=%0d: an=%b seg=%h dp=%b required an=%b seg=%h dp=%b",
                         k, an, seg, dp, exp[s][11:8], exp[s][7:1], exp[s][0]);
            end
            vectors++;
            if (frame_start !== ((k % 16) == 0)) begin
                errors++;
                $display("FAIL scan_frame_start k=%0d: frame_start=%b required %b",
                         k, frame_start, ((k % 16) == 0));
            end
        end
    endtask

    task automatic test_blanking;
        logic [11:0] exp [4];
        digits_in = 16'h0050;
        dp_in = 4'b0000;
        blank_leading_zeros = 1'b1;
        exp[0] = {4'b1110, 7'h40, 1'b1};
        exp[1] = {4'b1101, 7'h12, 1'b1};
        exp[2] = {4'b1111, 7'h7F, 1'b1};
        exp[3] = {4'b1111, 7'h7F, 1'b1};
        wait_frame();
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            vectors++;
            if ({an, seg, dp} !== exp[(k - 1) / 4]) begin
                errors++;
                $display("FAIL blank_0050 k=%0d: an=%b seg=%h dp=%b required an=%b seg=%h dp=%b",
                         k, an, seg, dp, exp[(k-1)/4][11:8], exp[(k-1)/4][7:1], exp[(k-1)/4][0]);
            end
        end
        dp_in = 4'b0100;
        exp[2] = {4'b1011, 7'h40, 1'b0};
        wait_frame();
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            vectors++;
            if ({an, seg, dp} !== exp[(k - 1) / 4]) begin
                errors++;
                $display("FAIL blank_dp2 k=%0d: an=%b seg=%h dp=%b required an=%b seg=%h dp=%b",
                         k, an, seg, dp, exp[(k-1)/4][11:8], exp[(k-1)/4][7:1], exp[(k-1)/4][0]);
            end
        end
    endtask

    task automatic test_shadow;
        logic [11:0] exp1 [4];
        logic [11:0] exp2 [4];
        int s;
        for (int i = 0; i < 4; i++) begin
            exp1[i] = {~(4'b0001 << i), 7'h79, 1'b1};
            exp2[i] = {~(4'b0001 << i), 7'h24, 1'b1};
        end
        digits_in = 16'h1111;
        dp_in = 4'b0000;
        blank_leading_zeros = 1'b0;
        wait_frame();
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 5) digits_in = 16'h2222;
            s = (k - 1) / 4;
            vectors++;
            if ({an, seg, dp} !== exp1[s]) begin
                errors++;
                $display("FAIL shadow_hold k=%0d: an=%b seg=%h required an=%b seg=%h",
                         k, an, seg, exp1[s][11:8], exp1[s][7:1]);
            end
        end
        vectors++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL shadow_frame_start: frame_start=%b required 1", frame_start);
        end
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            s = (k - 1) / 4;
            vectors++;
            if ({an, seg, dp} !== exp2[s]) begin
                errors++;
                $display("FAIL shadow_update k=%0d: an=%b seg=%h required an=%b seg=%h",
                         k, an, seg, exp2[s][11:8], exp2[s][7:1]);
            end
        end
    endtask

    task automatic test_overflow;
        digits_in = 16'hEEEE;
        blank_leading_zeros = 1'b1;
        wait_frame();
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            vectors++;
            if ({an, seg, dp} !== {~(4'b0001 << ((k - 1) / 4)), 7'h06, 1'b1}) begin
                errors++;
                $display("FAIL overflow k=%0d: an=%b seg=%h dp=%b required an=%b seg=06 dp=1",
                         k, an, seg, dp, ~(4'b0001 << ((k - 1) / 4)));
            end
        end
    endtask

    task automatic test_enable;
        digits_in = 16'h1234;
        blank_leading_zeros = 1'b0;
        enable = 1'b0;
        wait_frame();
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            vectors++;
            if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
                errors++;
                $display("FAIL enable_off k=%0d: an=%b seg=%h dp=%b required an=1111 seg=7f dp=1",
                         k, an, seg, dp);
            end
        end
        vectors++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL enable_off_frame_start: frame_start=%b required 1", frame_start);
        end
        enable = 1'b1;
        @(negedge clk);
        vectors++;
        if ({an, seg, dp} !== {4'b1110, 7'h19, 1'b1}) begin
            errors++;
            $display("FAIL enable_on: an=%b seg=%h dp=%b required an=1110 seg=19 dp=1", an, seg, dp);
        end
    endtask

    task automatic test_midscan_reset;
        digits_in = 16'h00A7;
        wait_frame();
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({an, seg, dp, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL midscan_reset: an=%b seg=%h dp=%b fs=%b required an=1111 seg=7f dp=1 fs=0",
                     an, seg, dp, frame_start);
        end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL midscan_restart_load: frame_start=%b required 1", frame_start);
        end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            vectors++;
            if ({an, seg} !== ((k <= 4) ? {4'b1110, 7'h78} : {4'b1101, 7'h08})) begin
                errors++;
                $display("FAIL midscan_restart k=%0d: an=%b seg=%h required an=%b seg=%h",
                         k, an, seg, (k <= 4) ? 4'b1110 : 4'b1101, (k <= 4) ? 7'h78 : 7'h08);
            end
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        test_reset();
        test_scan();
        test_blanking();
        test_shadow();
        test_overflow();
        test_enable();
        test_midscan_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
